// File: rtl/deal_hand_if.sv
// Control inputs, draw_once handshake and dealt-card stream of deal_hand.
interface deal_hand_if #(
  parameter int CARD_NUM = 106
);
  logic                interboard_rst;
  logic                init_deck;
  logic                ret_valid;
  logic [6:0]          ret_idx;
  logic                start;
  logic [3:0]          deal_cnt;
  logic                draw_ready;
  logic                draw_done;
  logic [6:0]          drawn_card_idx;
  logic                draw_one;
  logic [CARD_NUM-1:0] available_card;
  logic                busy;
  logic                card_valid;
  logic [3:0]          card_slot;
  logic [6:0]          card_idx;
  logic                deal_done;
  logic [1:0]          err;

  modport master (
    output interboard_rst, init_deck, ret_valid, ret_idx, start, deal_cnt,
           draw_ready, draw_done, drawn_card_idx,
    input  draw_one, available_card, busy, card_valid, card_slot, card_idx,
           deal_done, err
  );

  modport slave (
    input  interboard_rst, init_deck, ret_valid, ret_idx, start, deal_cnt,
           draw_ready, draw_done, drawn_card_idx,
    output draw_one, available_card, busy, card_valid, card_slot, card_idx,
           deal_done, err
  );
endinterface

// File: rtl/deal_hand.sv
// Deck owner/dealing sequencer in front of draw_once; cards leave one cycle after TAKE, REQ stalls on draw_ready.
// Optional draw_once watchdog enabled by defining DEAL_TIMEOUT_EN.
module deal_hand #(
  parameter int CARD_NUM  = 106,
  parameter int HAND_SIZE = 14,
  parameter int TO_CYC    = 255
) (
  input logic        clk,
  input logic        rst,
  deal_hand_if.slave dh
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, TAKE, FIN} state_t;

  localparam logic [6:0] IDX_LIM  = 7'(CARD_NUM);
  localparam logic [3:0] HAND_LIM = 4'(HAND_SIZE);
  localparam logic [7:0] TO_LIM   = 8'(TO_CYC - 1);
`ifdef DEAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t              state, state_n;
  logic [CARD_NUM-1:0] mask, mask_n;
  logic [3:0]          cnt, cnt_n;
  logic [3:0]          target, target_n;
  logic [6:0]          cap, cap_n;
  logic [7:0]          wd, wd_n;
  logic [1:0]          err, err_n;
  logic                draw_one_q, draw_one_n;
  logic                card_vld_q, card_vld_n;
  logic [3:0]          slot_q, slot_n;
  logic [6:0]          idx_q, idx_n;
  logic                take_ok;
  logic [3:0]          clamp;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    target_n   = target;
    cap_n      = cap;
    wd_n       = wd;
    err_n      = err;
    draw_one_n = 1'b0;
    card_vld_n = 1'b0;
    slot_n     = slot_q;
    idx_n      = idx_q;
    take_ok    = 1'b0;
    clamp      = (dh.deal_cnt > HAND_LIM) ? HAND_LIM : dh.deal_cnt;

    unique case (state)
      IDLE: begin
        if (dh.start) begin
          target_n = clamp;
          cnt_n    = '0;
          err_n    = '0;
          state_n  = (clamp == 4'd0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (mask == '0) begin
          err_n[0] = 1'b1;
          state_n  = FIN;
        end else if (dh.draw_ready) begin
          draw_one_n = 1'b1;
          wd_n       = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (dh.draw_done) begin
          cap_n   = dh.drawn_card_idx;
          state_n = TAKE;
        end else if (TO_EN && wd == TO_LIM) begin
          err_n   = 2'b11;
          state_n = FIN;
        end else begin
          wd_n = wd + 8'd1;
        end
      end
      TAKE: begin
        // Out-of-range or already-dealt index means draw_once misbehaved.
        if (cap >= IDX_LIM || !mask[cap]) begin
          err_n[1] = 1'b1;
          state_n  = FIN;
        end else begin
          take_ok    = 1'b1;
          card_vld_n = 1'b1;
          slot_n     = cnt;
          idx_n      = cap;
          cnt_n      = cnt + 4'd1;
          state_n    = ((cnt + 4'd1) == target) ? FIN : REQ;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Return is applied before the TAKE clear so a same-index collision leaves the card dealt.
  always_comb begin
    mask_n = mask;
    if (state == IDLE && dh.init_deck)
      mask_n = '1;
    if (dh.ret_valid && dh.ret_idx < IDX_LIM)
      mask_n[dh.ret_idx] = 1'b1;
    if (take_ok)
      mask_n[cap] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst || dh.interboard_rst) begin
      state      <= IDLE;
      mask       <= '1;
      cnt        <= '0;
      target     <= '0;
      cap        <= '0;
      wd         <= '0;
      err        <= '0;
      draw_one_q <= 1'b0;
      card_vld_q <= 1'b0;
      slot_q     <= '0;
      idx_q      <= '0;
    end else begin
      state      <= state_n;
      mask       <= mask_n;
      cnt        <= cnt_n;
      target     <= target_n;
      cap        <= cap_n;
      wd         <= wd_n;
      err        <= err_n;
      draw_one_q <= draw_one_n;
      card_vld_q <= card_vld_n;
      slot_q     <= slot_n;
      idx_q      <= idx_n;
    end
  end

  assign dh.draw_one       = draw_one_q;
  assign dh.available_card = mask;
  assign dh.busy           = (state != IDLE);
  assign dh.card_valid     = card_vld_q;
  assign dh.card_slot      = slot_q;
  assign dh.card_idx       = idx_q;
  assign dh.deal_done      = (state == FIN);
  assign dh.err            = err;
endmodule

// File: tb/tb_deal_hand.sv
// Directed bench for deal_hand with a behavioural draw_once responder.
module tb_deal_hand;
  localparam int CARD_NUM  = 106;
  localparam int HAND_SIZE = 14;
  localparam int TO_CYC    = 255;

  localparam int M_RAND     = 0;
  localparam int M_FIXED    = 1;
  localparam int M_SILENT   = 2;
  localparam int M_LOW      = 3;
  localparam int M_LOW_EXCL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   mode = M_RAND;
  logic [6:0] fix_idx = 7'd0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [3:0] mon_slot[$];
  logic [6:0] mon_idx[$];

  deal_hand_if #(.CARD_NUM(CARD_NUM)) dh ();

  deal_hand #(.CARD_NUM(CARD_NUM), .HAND_SIZE(HAND_SIZE), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .dh  (dh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] pick(input logic [CARD_NUM-1:0] m, input int md, input logic [6:0] fx);
    if (md == M_FIXED) return fx;
    if (md == M_RAND)
      for (int t = 0; t < 500; t++) begin
        int r;
        r = int'($urandom_range(CARD_NUM - 1));
        if (m[r]) return 7'(r);
      end
    for (int i = 0; i < CARD_NUM; i++)
      if (m[i] && !(md == M_LOW_EXCL && (i == 3 || i == 7))) return 7'(i);
    return 7'd0;
  endfunction

  // draw_once stand-in: answers each draw_one with a one-cycle done on the following edge.
  initial begin
    dh.draw_done      = 1'b0;
    dh.drawn_card_idx = 7'd0;
    forever begin
      @(negedge clk);
      dh.draw_done = 1'b0;
      if (dh.draw_one && mode != M_SILENT) begin
        dh.drawn_card_idx = pick(dh.available_card, mode, fix_idx);
        dh.draw_done      = 1'b1;
      end
    end
  end

  always @(negedge clk)
    if (dh.card_valid) begin
      mon_slot.push_back(dh.card_slot);
      mon_idx.push_back(dh.card_idx);
    end

  task automatic start_deal(input logic [3:0] cnt, input bit init);
    dh.deal_cnt  = cnt;
    dh.start     = 1'b1;
    dh.init_deck = init;
    @(negedge clk);
    dh.start     = 1'b0;
    dh.init_deck = 1'b0;
  endtask

  task automatic wait_deal();
    int cyc;
    cyc = 0;
    while (!dh.deal_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("deal_done_seen", 128'(dh.deal_done), 128'(1));
  endtask

  task automatic run_deal(input logic [3:0] cnt, input bit init, output int ncards, output int base);
    base = mon_idx.size();
    start_deal(cnt, init);
    wait_deal();
    @(negedge clk);
    ncards = mon_idx.size() - base;
  endtask

  task automatic wait_draw_one();
    int c;
    c = 0;
    while (!dh.draw_one && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("draw_one_seen", 128'(dh.draw_one), 128'(1));
  endtask

  // Deal one fixed card and return ret while that card sits in TAKE.
  task automatic take_with_ret(input logic [6:0] take, input logic [6:0] ret);
    mode    = M_FIXED;
    fix_idx = take;
    start_deal(4'd1, 1'b0);
    wait_draw_one();
    @(negedge clk);
    dh.ret_valid = 1'b1;
    dh.ret_idx   = ret;
    @(negedge clk);
    dh.ret_valid = 1'b0;
    wait_deal();
    @(negedge clk);
  endtask

  initial begin
    int n, base, dup, k, np;
    logic [CARD_NUM-1:0] all1, exp_m, m;
    all1 = '1;
    dh.interboard_rst = 1'b0;
    dh.init_deck      = 1'b0;
    dh.ret_valid      = 1'b0;
    dh.ret_idx        = 7'd0;
    dh.start          = 1'b0;
    dh.deal_cnt       = 4'd0;
    dh.draw_ready     = 1'b1;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mask", 128'(dh.available_card), 128'(all1));
    chk("rst_busy", 128'(dh.busy), 128'(0));
    chk("rst_draw_one", 128'(dh.draw_one), 128'(0));
    chk("rst_card_valid", 128'(dh.card_valid), 128'(0));
    chk("rst_deal_done", 128'(dh.deal_done), 128'(0));
    chk("rst_err", 128'(dh.err), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Full hand from a fresh deck, init and start in the same cycle.
    mode = M_RAND;
    run_deal(4'd14, 1'b1, n, base);
    chk("t1_ncards", 128'(n), 128'(14));
    for (int i = 0; i < 14 && i < n; i++)
      chk("t1_slot", 128'(mon_slot[base+i]), 128'(i));
    dup = 0;
    for (int i = 0; i < n; i++) begin
      if (dh.available_card[mon_idx[base+i]]) dup++;
      for (int j = i + 1; j < n; j++)
        if (mon_idx[base+i] == mon_idx[base+j]) dup++;
    end
    chk("t1_distinct_cleared", 128'(dup), 128'(0));
    chk("t1_popcount", 128'($countones(dh.available_card)), 128'(92));
    chk("t1_err", 128'(dh.err), 128'(0));
    chk("t1_busy", 128'(dh.busy), 128'(0));

    // Drain to a deck holding only cards 3 and 7.
    mode = M_LOW_EXCL;
    for (int it = 0; it < 10; it++) begin
      n = $countones(dh.available_card);
      if (it > 0 && n <= 2) break;
      k = (it == 0 || n - 2 > 14) ? 14 : n - 2;
      run_deal(4'(k), it == 0, np, base);
    end
    exp_m = '0;
    exp_m[3] = 1'b1;
    exp_m[7] = 1'b1;
    chk("t2_mask_pre", 128'(dh.available_card), 128'(exp_m));

    mode = M_LOW;
    dh.draw_ready = 1'b0;
    base = mon_idx.size();
    start_deal(4'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_stall_draw_one", 128'(dh.draw_one), 128'(0));
    chk("t2_stall_busy", 128'(dh.busy), 128'(1));
    dh.draw_ready = 1'b1;
    wait_deal();
    @(negedge clk);
    n = mon_idx.size() - base;
    chk("t2_ncards", 128'(n), 128'(2));
    if (n == 2) begin
      chk("t2_idx0", 128'(mon_idx[base]), 128'(3));
      chk("t2_idx1", 128'(mon_idx[base+1]), 128'(7));
      chk("t2_slot1", 128'(mon_slot[base+1]), 128'(1));
    end
    chk("t2_err", 128'(dh.err), 128'(1));
    chk("t2_mask", 128'(dh.available_card), 128'(0));

    // Out-of-range index from draw_once.
    mode    = M_FIXED;
    fix_idx = 7'd110;
    run_deal(4'd2, 1'b1, n, base);
    chk("t3_ncards", 128'(n), 128'(0));
    chk("t3_err", 128'(dh.err), 128'(2));
    chk("t3_mask", 128'(dh.available_card), 128'(all1));

    // Clamp to HAND_SIZE, and an empty request.
    mode = M_RAND;
    run_deal(4'd15, 1'b1, n, base);
    chk("clamp_ncards", 128'(n), 128'(14));
    chk("clamp_popcount", 128'($countones(dh.available_card)), 128'(92));
    chk("clamp_err_cleared", 128'(dh.err), 128'(0));
    run_deal(4'd0, 1'b0, n, base);
    chk("zero_ncards", 128'(n), 128'(0));

    // Returns colliding with TAKE.
    mode    = M_FIXED;
    fix_idx = 7'd9;
    run_deal(4'd1, 1'b1, n, base);
    chk("t4_bit9_dealt", 128'(dh.available_card[9]), 128'(0));
    take_with_ret(7'd5, 7'd5);
    chk("t4_same_idx_bit5", 128'(dh.available_card[5]), 128'(0));
    take_with_ret(7'd20, 7'd9);
    chk("t4_ret_bit9", 128'(dh.available_card[9]), 128'(1));
    chk("t4_take_bit20", 128'(dh.available_card[20]), 128'(0));
    m = dh.available_card;
    dh.ret_valid = 1'b1;
    dh.ret_idx   = 7'd120;
    @(negedge clk);
    dh.ret_idx   = 7'd20;
    @(negedge clk);
    dh.ret_valid = 1'b0;
    @(negedge clk);
    exp_m = m;
    exp_m[20] = 1'b1;
    chk("t4_ret_oob_then_20", 128'(dh.available_card), 128'(exp_m));

    // Reset while waiting on the 4th card.
    mode = M_RAND;
    base = mon_idx.size();
    start_deal(4'd8, 1'b1);
    np = 0;
    for (int c = 0; c < 200 && np < 4; c++) begin
      if (dh.draw_one) np++;
      if (np < 4) @(negedge clk);
    end
    chk("t5_draw_pulses", 128'(np), 128'(4));
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cards_before", 128'(mon_idx.size() - base), 128'(3));
    chk("t5_busy", 128'(dh.busy), 128'(0));
    chk("t5_draw_one", 128'(dh.draw_one), 128'(0));
    chk("t5_mask", 128'(dh.available_card), 128'(all1));
    rst = 1'b1;
    @(negedge clk);

    // Board-level abort mid-deal.
    start_deal(4'd5, 1'b0);
    repeat (2) @(negedge clk);
    dh.interboard_rst = 1'b1;
    @(negedge clk);
    dh.interboard_rst = 1'b0;
    chk("ibr_busy", 128'(dh.busy), 128'(0));
    chk("ibr_mask", 128'(dh.available_card), 128'(all1));
    @(negedge clk);

    // draw_once never answers.
    mode = M_SILENT;
    start_deal(4'd1, 1'b1);
    wait_draw_one();
    k = 0;
    while (!dh.deal_done && k < 400) begin
      @(negedge clk);
      k++;
    end
`ifdef DEAL_TIMEOUT_EN
    chk("t6_timeout_cycles", 128'(k), 128'(TO_CYC));
    chk("t6_err", 128'(dh.err), 128'(3));
`else
    chk("t6_no_done", 128'(dh.deal_done), 128'(0));
    chk("t6_busy_hold", 128'(dh.busy), 128'(1));
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_recover_busy", 128'(dh.busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
